// File: rtl/rcn_pkg.sv
// Shared definitions for the rcn ring to Avalon bridge: slot field positions,
// slot width, FSM state encoding and a slot builder.
package rcn_pkg;

  localparam int RCN_W    = 69;
  localparam int VLD_B    = 68;
  localparam int PEND_B   = 67;
  localparam int WR_B     = 66;
  localparam int ID_LSB   = 60;
  localparam int ID_W     = 6;
  localparam int MASK_LSB = 56;
  localparam int MASK_W   = 4;
  localparam int ADDR_LSB = 34;
  localparam int ADDR_W   = 22;
  localparam int SEQ_LSB  = 32;
  localparam int SEQ_W    = 2;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 32;

  localparam logic [7:0]        TMO_LIMIT    = 8'd255;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RDWAIT,
    ST_RESP
  } state_e;

  function automatic logic [RCN_W-1:0] rcn_slot(
    input logic              vld,
    input logic              pend,
    input logic              wr,
    input logic [ID_W-1:0]   id,
    input logic [MASK_W-1:0] mask,
    input logic [ADDR_W-1:0] addr,
    input logic [SEQ_W-1:0]  seq,
    input logic [DATA_W-1:0] data
  );
    return {vld, pend, wr, id, mask, addr, seq, data};
  endfunction

endpackage

// File: rtl/rcn2avalon_if.sv
// Avalon-MM master bus bundle used by the rcn2avalon bridge.
interface rcn2avalon_if;
  import rcn_pkg::*;

  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [3:0]        av_byteenable;
  logic [DATA_W-1:0] av_writedata;
  logic              av_waitrequest;
  logic [DATA_W-1:0] av_readdata;
  logic              av_readdatavalid;

  modport master (
    output av_address, av_read, av_write, av_byteenable, av_writedata,
    input  av_waitrequest, av_readdata, av_readdatavalid
  );

  modport slave (
    input  av_address, av_read, av_write, av_byteenable, av_writedata,
    output av_waitrequest, av_readdata, av_readdatavalid
  );

endinterface

// File: rtl/rcn2avalon_timer.sv
// Stall watchdog for rcn2avalon: counts while run_i is high, clears otherwise,
// and flags expiry on the limit count. Only built with RCN2AVALON_TIMEOUT_EN.
module rcn2avalon_timer
  import rcn_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = run_i ? cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = run_i && (cnt_q == TMO_LIMIT);

endmodule

// File: rtl/rcn2avalon.sv
// rcn ring node that turns pending requests in its address window into single
// Avalon-MM transactions. Optional stall timeout under RCN2AVALON_TIMEOUT_EN.
module rcn2avalon
  import rcn_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_MASK = 22'h3F0000,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 22'h000000
) (
  input  logic             av_clk,
  input  logic             av_rst_n,
  input  logic [RCN_W-1:0] rcn_in,
  output logic [RCN_W-1:0] rcn_out,
  rcn2avalon_if.master     av
);

  state_e            state_q, state_d;
  logic [RCN_W-1:0]  rin_q;
  logic [RCN_W-1:0]  rout_q, rout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MASK_W-1:0] be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              cap_wr_q, cap_wr_d;
  logic [ID_W-1:0]   cap_id_q, cap_id_d;
  logic [SEQ_W-1:0]  cap_seq_q, cap_seq_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;

  logic              rin_vld, rin_pend, rin_wr, hit, accept, tmo_expired;
  logic [ID_W-1:0]   rin_id;
  logic [MASK_W-1:0] rin_mask;
  logic [ADDR_W-1:0] rin_addr;
  logic [SEQ_W-1:0]  rin_seq;
  logic [DATA_W-1:0] rin_data;

  assign rin_vld  = rin_q[VLD_B];
  assign rin_pend = rin_q[PEND_B];
  assign rin_wr   = rin_q[WR_B];
  assign rin_id   = rin_q[ID_LSB +: ID_W];
  assign rin_mask = rin_q[MASK_LSB +: MASK_W];
  assign rin_addr = rin_q[ADDR_LSB +: ADDR_W];
  assign rin_seq  = rin_q[SEQ_LSB +: SEQ_W];
  assign rin_data = rin_q[DATA_LSB +: DATA_W];

  // Only pending (request) slots are ever consumed; responses always pass.
  assign hit    = rin_vld && rin_pend && ((rin_addr & ADDR_MASK) == ADDR_BASE);
  assign accept = (rd_q || wr_q) && !av.av_waitrequest;

`ifdef RCN2AVALON_TIMEOUT_EN
  rcn2avalon_timer u_timer (
    .clk_i     (av_clk),
    .rst_ni    (av_rst_n),
    .run_i     ((state_q == ST_ISSUE) || (state_q == ST_RDWAIT)),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rout_d     = rin_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cap_wr_d   = cap_wr_q;
    cap_id_d   = cap_id_q;
    cap_seq_d  = cap_seq_q;
    cap_data_d = cap_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          rout_d     = '0;
          addr_d     = rin_addr;
          be_d       = rin_mask;
          wdata_d    = rin_data;
          rd_d       = !rin_wr;
          wr_d       = rin_wr;
          cap_wr_d   = rin_wr;
          cap_id_d   = rin_id;
          cap_seq_d  = rin_seq;
          cap_data_d = rin_data;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = cap_wr_q ? ST_RESP : ST_RDWAIT;
        end else if (tmo_expired) begin
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          cap_data_d = TIMEOUT_DATA;
          state_d    = ST_RESP;
        end
      end
      ST_RDWAIT: begin
        if (av.av_readdatavalid) begin
          cap_data_d = av.av_readdata;
          state_d    = ST_RESP;
        end else if (tmo_expired) begin
          cap_data_d = TIMEOUT_DATA;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        // Wait for an empty ring slot; occupied slots keep flowing meanwhile.
        if (!rin_vld) begin
          rout_d  = rcn_slot(1'b1, 1'b0, cap_wr_q, cap_id_q, be_q, addr_q,
                             cap_seq_q, cap_data_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge av_clk) begin
    if (!av_rst_n) begin
      state_q <= ST_IDLE;
      rin_q   <= '0;
      rout_q  <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rin_q   <= rcn_in;
      rout_q  <= rout_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge av_clk) begin
    cap_wr_q   <= cap_wr_d;
    cap_id_q   <= cap_id_d;
    cap_seq_q  <= cap_seq_d;
    cap_data_q <= cap_data_d;
  end

  assign rcn_out          = rout_q;
  assign av.av_address    = addr_q;
  assign av.av_byteenable = be_q;
  assign av.av_writedata  = wdata_q;
  assign av.av_read       = rd_q;
  assign av.av_write      = wr_q;

endmodule

// File: tb/tb_rcn2avalon.sv
// Bench for rcn2avalon: ring-level reference model (slot stream delayed two
// cycles, request freed, response in first empty slot) plus a scripted slave.
module tb_rcn2avalon;

  localparam logic [21:0] MASK = 22'h3F0000;
  localparam logic [21:0] BASE = 22'h000000;

  logic        av_clk = 1'b0;
  logic        av_rst_n;
  logic [68:0] rcn_in;
  logic [68:0] rcn_out;
  int          checks = 0;
  int          failures = 0;
  logic [68:0] in_a  [0:511];

  rcn2avalon_if av_bus ();

  rcn2avalon #(.ADDR_MASK(MASK), .ADDR_BASE(BASE)) dut (
    .av_clk   (av_clk),
    .av_rst_n (av_rst_n),
    .rcn_in   (rcn_in),
    .rcn_out  (rcn_out),
    .av       (av_bus)
  );

  always #5 av_clk = ~av_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [68:0] mk(input logic v, input logic p, input logic w,
      input logic [5:0] id, input logic [3:0] m, input logic [21:0] a,
      input logic [1:0] s, input logic [31:0] d);
    return {v, p, w, id, m, a, s, d};
  endfunction

  function automatic logic [21:0] hit_addr();
    return {6'd0, 16'($urandom)};
  endfunction

  function automatic logic [21:0] miss_addr();
    return {6'($urandom_range(1, 63)), 16'($urandom)};
  endfunction

  // Arbitrary occupied slot: request or response, inside or outside the window.
  function automatic logic [68:0] rnd_slot();
    return mk(1'b1, 1'($urandom), 1'($urandom), 6'($urandom), 4'($urandom),
              $urandom_range(0, 1) ? hit_addr() : miss_addr(), 2'($urandom), $urandom);
  endfunction

  task automatic tick();
    @(posedge av_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk(tag, {av_bus.av_read, av_bus.av_write}, 2'b00);
  endtask

  // One hit transaction. Slot in_a[k] is driven after edge k and, unless it is
  // the consumed request or the chosen empty slot, reappears after edge k+2.
  // The command is visible after edges 2..a-1; the slave stalls nwait cycles.
  task automatic run_txn(input logic [68:0] req, input int nwait, input int rdlat,
                         input logic [31:0] rdval, input int nbusy,
                         input logic [68:0] hit2, input bit to);
    int          a, c, j, len;
    bit          on;
    logic        w;
    logic [68:0] rsp, exp_o;
    w   = req[66];
    a   = to ? 258 : 3 + nwait;
    c   = (to || w) ? a : a + rdlat;
    len = c + nbusy + 5;
    for (int k = 0; k < len; k++) in_a[k] = '0;
    in_a[0] = req;
    for (int k = 1; k < c - 1; k++) if ($urandom_range(0, 1) == 1) in_a[k] = rnd_slot();
    if (hit2 != '0) in_a[c-2] = hit2;
    for (int k = c - 1; k < c - 1 + nbusy; k++) in_a[k] = rnd_slot();
    j = c - 1;
    while (in_a[j][68]) j++;
    rsp = mk(1'b1, 1'b0, w, req[65:60], req[59:56], req[55:34], req[33:32],
             to ? 32'hDEADBEEF : (w ? req[31:0] : rdval));
    for (int e = 0; e < len; e++) begin
      on = (e >= 2) && (e <= a - 1);
      if (e >= 2) begin
        exp_o = (e == 2) ? 69'd0 : ((e - 2 == j) ? rsp : in_a[e-2]);
        chk("rcn_out", rcn_out, exp_o);
        chk("cmd", {av_bus.av_read, av_bus.av_write}, {on && !w, on && w});
        if (on) begin
          chk("addr_be", {av_bus.av_address, av_bus.av_byteenable}, {req[55:34], req[59:56]});
          if (w) chk("wdata", av_bus.av_writedata, req[31:0]);
        end
      end
      rcn_in = in_a[e];
      if (e >= 2 && e <= a - 2)  av_bus.av_waitrequest = 1'b1;
      else if (e == a - 1)       av_bus.av_waitrequest = to;
      else                       av_bus.av_waitrequest = 1'($urandom);
      if (!w && !to && e >= a && e <= c - 1) begin
        av_bus.av_readdatavalid = (e == c - 1);
        av_bus.av_readdata      = (e == c - 1) ? rdval : $urandom;
      end else begin
        av_bus.av_readdatavalid = 1'($urandom);
        av_bus.av_readdata      = $urandom;
      end
      tick();
    end
    av_bus.av_readdatavalid = 1'b0;
    av_bus.av_waitrequest   = 1'b0;
  endtask

  // Slot that must not be consumed: reappears unchanged two edges later.
  task automatic run_pass(input logic [68:0] slot);
    rcn_in = slot;
    tick();
    rcn_in = '0;
    chk_idle_bus("pass_cmd1");
    tick();
    chk("pass_out", rcn_out, slot);
    chk_idle_bus("pass_cmd2");
    tick();
    chk("pass_after", rcn_out, 69'd0);
    tick();
  endtask

  initial begin
    av_rst_n = 1'b0;
    rcn_in   = mk(1'b1, 1'b1, 1'b1, 6'h01, 4'hF, 22'h000020, 2'd1, 32'h1);
    av_bus.av_waitrequest   = 1'b0;
    av_bus.av_readdata      = '0;
    av_bus.av_readdatavalid = 1'b0;
    repeat (3) tick();
    chk("rst_out", rcn_out, 69'd0);
    chk("rst_bus", {av_bus.av_read, av_bus.av_write, av_bus.av_address,
                    av_bus.av_byteenable, av_bus.av_writedata}, '0);
    rcn_in   = '0;
    av_rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_out", rcn_out, 69'd0);

    // Zero-wait write: response three cycles after the request is registered.
    run_txn(mk(1'b1, 1'b1, 1'b1, 6'h3F, 4'hF, 22'h000010, 2'd2, 32'h12345678),
            0, 1, 32'h0, 0, '0, 1'b0);
    // Read stalled four cycles, data two cycles after acceptance.
    run_txn(mk(1'b1, 1'b1, 1'b0, 6'h05, 4'h3, 22'h000104, 2'd1, 32'h0),
            4, 2, 32'hCAFEF00D, 0, '0, 1'b0);
    // Misses, responses in the window and invalid slots all pass untouched.
    run_pass(mk(1'b1, 1'b1, 1'b1, 6'h11, 4'hF, 22'h010000, 2'd0, 32'hA5A5A5A5));
    run_pass(mk(1'b1, 1'b0, 1'b1, 6'h12, 4'hF, 22'h000010, 2'd3, 32'h5A5A5A5A));
    run_pass(mk(1'b0, 1'b1, 1'b0, 6'h13, 4'h1, 22'h000008, 2'd1, 32'h0));
    // Second hit during the read wait, then five occupied slots in RESP.
    run_txn(mk(1'b1, 1'b1, 1'b0, 6'h21, 4'hF, 22'h000200, 2'd0, 32'h0),
            0, 3, 32'h0BADCAFE, 5,
            mk(1'b1, 1'b1, 1'b1, 6'h22, 4'hC, 22'h000300, 2'd3, 32'h77778888), 1'b0);

    // Reset while the command is stalled: command drops, nothing comes back.
    rcn_in = mk(1'b1, 1'b1, 1'b1, 6'h2A, 4'hF, 22'h000040, 2'd1, 32'hFEEDFACE);
    av_bus.av_waitrequest = 1'b1;
    tick();
    rcn_in = '0;
    tick();
    tick();
    chk("pre_rst_cmd", {av_bus.av_read, av_bus.av_write}, 2'b01);
    av_rst_n = 1'b0;
    tick();
    av_rst_n = 1'b1;
    chk("mid_rst_bus", {av_bus.av_read, av_bus.av_write, av_bus.av_address,
                        av_bus.av_byteenable, av_bus.av_writedata}, '0);
    chk("mid_rst_out", rcn_out, 69'd0);
    for (int i = 0; i < 12; i++) begin
      av_bus.av_waitrequest   = 1'($urandom);
      av_bus.av_readdatavalid = 1'($urandom);
      tick();
      chk("post_rst_out", rcn_out, 69'd0);
      chk_idle_bus("post_rst_cmd");
    end
    av_bus.av_waitrequest   = 1'b0;
    av_bus.av_readdatavalid = 1'b0;
    run_txn(mk(1'b1, 1'b1, 1'b1, 6'h2B, 4'h6, 22'h000044, 2'd2, 32'h01020304),
            1, 1, 32'h0, 1, '0, 1'b0);

`ifdef RCN2AVALON_TIMEOUT_EN
    run_txn(mk(1'b1, 1'b1, 1'b1, 6'h30, 4'hF, 22'h000500, 2'd1, 32'h11111111),
            0, 1, 32'h0, 2, '0, 1'b1);
`endif

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_pass(mk(1'b1, 1'($urandom), 1'($urandom), 6'($urandom), 4'($urandom),
                    miss_addr(), 2'($urandom), $urandom));
      end else begin
        run_txn(mk(1'b1, 1'b1, 1'($urandom), 6'($urandom), 4'($urandom), hit_addr(),
                   2'($urandom), $urandom),
                $urandom_range(0, 5), $urandom_range(1, 4), $urandom,
                $urandom_range(0, 3), '0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
